stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised 1-to-N_CH packet demultiplexer with valid/ready handshaking and a registered, one-entry output slot per channel. The destination is sampled on the first beat of each packet and held until the beat carrying `s_last`; out-of-range destinations are dropped and flagged. It replaces the fixed 1x8 combinational demux wherever routed data must tolerate per-channel backpressure.

## Interface
- `N_CH`, 8, number of output channels, 2..64, need not be a power of two
- `DATA_W`, 8, payload width in bits, ≥1
- `SEL_W`, derived as max(1, clog2(N_CH)), not overridable

- `clk` in 1: single clock, all logic on its rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low; release synchronised externally
- `s_valid` in 1: input beat valid
- `s_ready` out 1: input beat accepted when `s_valid && s_ready` at a rising edge
- `s_data` in DATA_W: input payload
- `s_last` in 1: final beat of the packet
- `s_sel` in SEL_W: destination channel, sampled only on a packet's first beat
- `m_valid` out N_CH: per-channel output valid
- `m_ready` in N_CH: per-channel output ready
- `m_data` out N_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W]
- `m_last` out N_CH: per-channel last flag
- `busy` out 1: high in ROUTE or DROP
- `sel_err` out 1: one-cycle pulse when a packet with `s_sel >= N_CH` is accepted

## Operation
- FSM states: IDLE, ROUTE, DROP. Reset state: IDLE.
- IDLE: the destination is `s_sel` as presented. On an accepted beat with `s_sel < N_CH`, the beat is written into slot `s_sel` and `cur_sel` is latched. Next state is IDLE if `s_last`, otherwise ROUTE.
- IDLE, out of range: on an accepted beat with `s_sel >= N_CH`, the beat is discarded and `sel_err` pulses on the next cycle. Next state is IDLE if `s_last`, otherwise DROP.
- ROUTE: every accepted beat goes to slot `cur_sel`, and `s_sel` is ignored. An accepted `s_last` beat returns the FSM to IDLE.
- DROP: `s_ready` is 1. Every beat is discarded, and an accepted `s_last` beat returns the FSM to IDLE.
- Slot: holds `valid`, `data` and `last`.
  - Load when empty, or when full and `m_ready[i]` is high in the same cycle (pass-through refill, no bubble).
  - Clear when full, `m_ready[i]` is high and there is no load.
- `s_ready`:
  - IDLE: equals slot(`s_sel`) empty OR `m_ready[s_sel]`; equals 1 when `s_sel >= N_CH`.
  - ROUTE: same rule applied to `cur_sel`.
  - DROP: 1.
  - No combinational path from `s_valid` to `s_ready`.
- Channel independence: channels not addressed drain independently. A new packet may start to channel B while channel A's slot still holds data.
- `m_data` and `m_last` of an empty slot hold their last value. Only `m_valid` is meaningful.

## Timing
- Reset values (while `rst_n` is low, asynchronously): `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `sel_err`=0, `s_ready`=0. The FSM is in IDLE.
- Latency: a beat accepted at edge k is visible on `m_*[ch]` from just after edge k, i.e. one cycle.
- Throughput: 1 beat/cycle sustained when the destination's `m_ready` is held high.
- Output stability: `m_valid[i]` stays high with stable `m_data`/`m_last` until `m_ready[i]` is sampled high.
- Single-beat packet (`s_last` on the first beat): routed from IDLE, and the FSM stays in IDLE.
- Back-to-back packets: a packet to a different channel may be accepted on the cycle immediately after the previous `s_last`.
- Reset mid-packet: all slot contents and `cur_sel` are discarded, and the FSM is in IDLE. The remainder of the upstream packet is treated as a new packet.
- `sel_err` is registered. It is asserted on the cycle after the offending first beat is accepted, for exactly one cycle.

## Structure
- Package `stream_demux_pkg`:
  - state enum `demux_state_t` {IDLE, ROUTE, DROP}
  - function `sel_width(n)` returning max(1, clog2(n))
- Sub-module `stream_demux_slot` (params `DATA_W`): a one-entry valid/ready register with pass-through refill, generated N_CH times.
- The top level holds the FSM, `cur_sel` and the `s_ready` mux only.

## Test plan
- Case 1: N_CH=8, DATA_W=8, all `m_ready`=1. Send a 3-beat packet with `s_sel`=5 and data 0x11/0x22/0x33. Required: `m_valid[5]` for 3 consecutive cycles starting one cycle after the first accept, with `m_last[5]` on 0x33. No other channel is valid.
- Case 2: Packet to channel 2 with `m_ready[2]`=0 for 4 cycles. Required: after one beat `s_ready`=0, and `m_data[2]` holds its first beat. When `m_ready[2]` goes to 1, the remaining beats flow with no loss and no duplication.
- Case 3: Channel 0 stalled and full, then a packet to channel 7 is sent. Required: the channel-7 beats are accepted and delivered while channel 0 still holds its beat.
- Case 4: N_CH=6, `s_sel`=7, 2-beat packet. Required: `s_ready`=1, both beats are dropped, `sel_err` pulses once, and no `m_valid` is asserted.
- Case 5: Mid-packet to channel 3, with `s_sel` changed to 1 on beat 2. Required: beat 2 still goes to channel 3.
- Case 6: Assert `rst_n`=0 mid-packet with full slots. Required: all outputs return to reset values immediately. After release, a packet to channel 4 routes correctly.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux packet router.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } demux_state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready output register with pass-through refill.
module stream_demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              w_load;

    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_CH packet demultiplexer: destination latched on the first beat,
// out-of-range packets dropped and flagged, one registered slot per channel.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    input  logic [SEL_W-1:0]         s_sel,
    output logic [N_CH-1:0]          m_valid,
    input  logic [N_CH-1:0]          m_ready,
    output logic [N_CH*DATA_W-1:0]   m_data,
    output logic [N_CH-1:0]          m_last,
    output logic                     busy,
    output logic                     sel_err
);

    localparam int EXT_N = 1 << SEL_W;

    demux_state_t     r_state;
    demux_state_t     w_state_nxt;
    logic [SEL_W-1:0] r_cur_sel;
    logic             r_sel_err;
    logic [SEL_W-1:0] w_dest;
    logic             w_dest_ok;
    logic             w_accept;
    logic [N_CH-1:0]  w_slot_rdy;
    logic [N_CH-1:0]  w_load;
    logic [EXT_N-1:0] w_rdy_ext;

    assign w_dest    = (r_state == ROUTE) ? r_cur_sel : s_sel;
    assign w_dest_ok = (r_state != DROP) && (int'(w_dest) < N_CH);

    // Unused select codes read as ready so out-of-range packets are drained.
    always_comb begin
        w_rdy_ext = '1;
        w_rdy_ext[N_CH-1:0] = w_slot_rdy;
    end

    assign s_ready  = rst_n && ((r_state == DROP) || w_rdy_ext[w_dest]);
    assign w_accept = s_valid && s_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !s_last)
                    w_state_nxt = w_dest_ok ? ROUTE : DROP;
            end
            ROUTE, DROP: begin
                if (w_accept && s_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cur_sel <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_err <= w_accept && (r_state == IDLE) && !w_dest_ok;
            if (w_accept && (r_state == IDLE))
                r_cur_sel <= s_sel;
        end
    end

    assign busy    = (r_state != IDLE);
    assign sel_err = r_sel_err;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        assign w_load[i] = w_accept && w_dest_ok && (w_dest == SEL_W'(i));

        stream_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_load[i]),
            .o_ready (w_slot_rdy[i]),
            .i_data  (s_data),
            .i_last  (s_last),
            .o_valid (m_valid[i]),
            .i_ready (m_ready[i]),
            .o_data  (m_data[i*DATA_W +: DATA_W]),
            .o_last  (m_last[i])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: two instances (8 and 6 channels) checked every
// cycle against a packet-level model, plus directed literal scenarios.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sv[2];
    logic [7:0] sd[2];
    logic       sl[2];
    logic [2:0] ss[2];
    logic [7:0] mr[2];
    logic       srdy[2];
    logic       bz[2];
    logic       se[2];

    logic [7:0]  mv8, ml8;
    logic [63:0] md8;
    logic [5:0]  mv6, ml6;
    logic [47:0] md6;
    logic [7:0]  mv[2], ml[2];
    logic [63:0] md[2];

    assign mv[0] = mv8;
    assign ml[0] = ml8;
    assign md[0] = md8;
    assign mv[1] = {2'b00, mv6};
    assign ml[1] = {2'b00, ml6};
    assign md[1] = {16'h0, md6};

    stream_demux #(.N_CH(8), .DATA_W(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (sv[0]),
        .s_ready (srdy[0]),
        .s_data  (sd[0]),
        .s_last  (sl[0]),
        .s_sel   (ss[0]),
        .m_valid (mv8),
        .m_ready (mr[0]),
        .m_data  (md8),
        .m_last  (ml8),
        .busy    (bz[0]),
        .sel_err (se[0])
    );

    stream_demux #(.N_CH(6), .DATA_W(8)) u_dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (sv[1]),
        .s_ready (srdy[1]),
        .s_data  (sd[1]),
        .s_last  (sl[1]),
        .s_sel   (ss[1]),
        .m_valid (mv6),
        .m_ready (mr[1][5:0]),
        .m_data  (md6),
        .m_last  (ml6),
        .busy    (bz[1]),
        .sel_err (se[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packet-level model: a packet is either open or not; its destination
    // is a plain channel number, and a destination >= nch means discard.
    int        nch[2] = '{8, 6};
    bit        in_pkt[2];
    int        cur[2];
    bit        has[2][8];
    bit [7:0]  dat[2][8];
    bit        lst[2][8];
    bit        serr[2];
    logic [8:0] oq[2][8][$];
    bit        rnd[2];

    function automatic int dest_of(int k);
        return in_pkt[k] ? cur[k] : int'(ss[k]);
    endfunction

    function automatic bit exp_ready(int k);
        int d;
        if (!rst_n) return 1'b0;
        d = dest_of(k);
        if (d >= nch[k]) return 1'b1;
        return !has[k][d] || mr[k][d];
    endfunction

    function automatic void mdl_reset();
        for (int k = 0; k < 2; k++) begin
            in_pkt[k] = 0;
            cur[k]    = 0;
            serr[k]   = 0;
            for (int c = 0; c < 8; c++) begin
                has[k][c] = 0;
                dat[k][c] = '0;
                lst[k][c] = 0;
            end
        end
    endfunction

    function automatic void mdl_step(int k);
        bit acc;
        int d;
        acc = sv[k] && exp_ready(k);
        d   = dest_of(k);
        for (int c = 0; c < nch[k]; c++) begin
            if (acc && d == c) begin
                has[k][c] = 1;
                dat[k][c] = sd[k];
                lst[k][c] = sl[k];
            end else if (has[k][c] && mr[k][c]) begin
                has[k][c] = 0;
            end
        end
        serr[k] = acc && !in_pkt[k] && d >= nch[k];
        if (acc) begin
            in_pkt[k] = !sl[k];
            cur[k]    = d;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl_reset();
        else for (int k = 0; k < 2; k++) mdl_step(k);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("i%0d_rst_valid", k), mv[k], 0);
                chk($sformatf("i%0d_rst_data", k), md[k], 0);
                chk($sformatf("i%0d_rst_last", k), ml[k], 0);
                chk($sformatf("i%0d_rst_ready", k), srdy[k], 0);
                chk($sformatf("i%0d_rst_busy", k), bz[k], 0);
                chk($sformatf("i%0d_rst_selerr", k), se[k], 0);
            end else begin
                logic [7:0] ev;
                ev = '0;
                for (int c = 0; c < 8; c++) ev[c] = has[k][c];
                chk($sformatf("i%0d_mvalid", k), mv[k], ev);
                chk($sformatf("i%0d_sready", k), srdy[k], exp_ready(k));
                chk($sformatf("i%0d_busy", k), bz[k], in_pkt[k]);
                chk($sformatf("i%0d_selerr", k), se[k], serr[k]);
                for (int c = 0; c < nch[k]; c++) begin
                    if (has[k][c]) begin
                        chk($sformatf("i%0d_data%0d", k, c),
                            md[k][c*8 +: 8], dat[k][c]);
                        chk($sformatf("i%0d_last%0d", k, c),
                            ml[k][c], lst[k][c]);
                    end
                    if (mv[k][c] && mr[k][c])
                        oq[k][c].push_back({ml[k][c], md[k][c*8 +: 8]});
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++)
            if (rnd[k]) mr[k] = 8'($urandom);
    end

    task automatic send(input int k, input int sel, input logic [7:0] d,
                        input logic l);
        bit acc;
        int n;
        sv[k] = 1'b1;
        ss[k] = 3'(sel);
        sd[k] = d;
        sl[k] = l;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = srdy[k];
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL i%0d_accept_timeout: got 0 expected 1", k);
        end
        sv[k] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearq();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 8; c++) oq[k][c].delete();
    endtask

    initial begin
        mdl_reset();
        for (int k = 0; k < 2; k++) begin
            sv[k] = 0; sd[k] = 0; sl[k] = 0; ss[k] = 0;
            mr[k] = '1; rnd[k] = 0;
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Case 1: 3-beat packet to channel 5, one-cycle latency, no gaps
        clearq();
        send(0, 5, 8'h11, 0);
        chk("c1_v1", mv[0], 8'h20);
        chk("c1_d1", md[0][40 +: 8], 8'h11);
        send(0, 5, 8'h22, 0);
        chk("c1_v2", mv[0], 8'h20);
        chk("c1_d2", md[0][40 +: 8], 8'h22);
        send(0, 5, 8'h33, 1);
        chk("c1_v3", mv[0], 8'h20);
        chk("c1_d3", md[0][40 +: 8], 8'h33);
        chk("c1_l3", ml[0][5], 1);
        cycles(1);
        chk("c1_empty", mv[0], 8'h00);

        // Case 2: backpressure on channel 2
        clearq();
        mr[0] = 8'hFB;
        send(0, 2, 8'hA1, 0);
        chk("c2_stall_rdy", srdy[0], 0);
        chk("c2_hold", md[0][16 +: 8], 8'hA1);
        fork
            begin
                cycles(4);
                mr[0] = 8'hFF;
            end
            begin
                send(0, 2, 8'hA2, 0);
                send(0, 2, 8'hA3, 1);
            end
        join
        cycles(3);
        chk("c2_count", oq[0][2].size(), 3);
        chk("c2_b0", oq[0][2][0], 9'h0A1);
        chk("c2_b1", oq[0][2][1], 9'h0A2);
        chk("c2_b2", oq[0][2][2], 9'h1A3);

        // Case 3: channel 0 stalled, channel 7 still flows
        clearq();
        mr[0] = 8'hFE;
        send(0, 0, 8'hC0, 1);
        send(0, 7, 8'hD1, 0);
        send(0, 7, 8'hD2, 1);
        cycles(2);
        chk("c3_ch0_held", mv[0][0], 1);
        chk("c3_ch0_data", md[0][0 +: 8], 8'hC0);
        chk("c3_ch7_count", oq[0][7].size(), 2);
        chk("c3_ch7_b1", oq[0][7][1], 9'h1D2);
        mr[0] = 8'hFF;
        cycles(2);

        // Case 4: out-of-range destination on the 6-channel instance
        clearq();
        ss[1] = 3'd7;
        #1;
        chk("c4_rdy", srdy[1], 1);
        send(1, 7, 8'hE1, 0);
        chk("c4_err_pulse", se[1], 1);
        chk("c4_busy", bz[1], 1);
        send(1, 2, 8'hE2, 1);
        chk("c4_err_once", se[1], 0);
        chk("c4_novalid", mv[1], 8'h00);
        chk("c4_idle", bz[1], 0);

        // Case 5: s_sel changing mid-packet is ignored
        clearq();
        send(0, 3, 8'h51, 0);
        send(0, 1, 8'h52, 1);
        cycles(2);
        chk("c5_ch3_count", oq[0][3].size(), 2);
        chk("c5_ch3_b1", oq[0][3][1], 9'h152);
        chk("c5_ch1_count", oq[0][1].size(), 0);

        // Case 6: reset mid-packet with full slots
        mr[0] = 8'h00;
        send(0, 1, 8'h61, 1);
        send(0, 2, 8'h62, 1);
        send(0, 3, 8'h63, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c6_valid", mv[0], 8'h00);
        chk("c6_data", md[0], 64'h0);
        chk("c6_ready", srdy[0], 0);
        chk("c6_busy", bz[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mr[0] = 8'hFF;
        clearq();
        send(0, 4, 8'h64, 0);
        send(0, 4, 8'h65, 1);
        cycles(2);
        chk("c6_ch4_count", oq[0][4].size(), 2);
        chk("c6_ch4_b0", oq[0][4][0], 9'h064);
        chk("c6_ch4_b1", oq[0][4][1], 9'h165);

        // Randomised traffic on both instances
        for (int k = 0; k < 2; k++) begin
            rnd[k] = 1;
            for (int p = 0; p < 60; p++) begin
                int sel;
                int len;
                sel = $urandom_range(0, 7);
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    send(k, (b == 0) ? sel : $urandom_range(0, 7),
                         8'($urandom), b == len - 1);
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
            end
            rnd[k] = 0;
            cycles(1);
            mr[k] = '1;
            cycles(4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
